// File: rtl/sub_seq_if.sv
// sub_seq_if: operand/handshake/result bundle for the sequential subtractor.
//   master : drives a, b, bin, start; observes busy, done, diff, bout, ovf, zero
//   slave  : the subtractor side (sub_seq)
// Parameter N is the operand/result width and must match the attached sub_seq.
interface sub_seq_if #(
    parameter int N = 8
);
    logic [N-1:0] a;      // minuend
    logic [N-1:0] b;      // subtrahend
    logic         bin;    // borrow-in
    logic         start;  // request, accepted only when idle
    logic         busy;   // high while chunks are being processed
    logic         done;   // one-cycle pulse when results update
    logic [N-1:0] diff;   // registered result
    logic         bout;   // borrow-out (a < b + bin, unsigned)
    logic         ovf;    // two's-complement overflow of a - b - bin
    logic         zero;   // diff == 0

    modport master (
        output a, b, bin, start,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  a, b, bin, start,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/sub_seq.sv
// sub_seq: multi-cycle subtractor computing diff = a - b - bin, K bits per clock.
//
// Ports:
//   clk    - rising-edge system clock
//   rst_n  - asynchronous active-low reset
//   bus    - sub_seq_if.slave: a, b, bin, start in; busy, done, diff, bout,
//            ovf, zero out (all outputs registered)
//
// Parameters:
//   N - operand/result width
//   K - bits processed per clock; K must divide N, 1 <= K <= N
//
// Optional build macro:
//   SUB_SAT_EN - when defined, a final borrow clamps diff to zero (unsigned
//                saturation); bout/ovf still describe the raw result.
//
// Operation: the accepting edge (start high in IDLE) captures the operands and
// seeds the chunk carry with ~bin. Each RUN edge adds a_i + ~b_i + carry for one
// K-bit chunk, least significant chunk first. The edge that finishes the last
// chunk loads the outputs and enters DONE for a single cycle.
module sub_seq #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    sub_seq_if.slave  bus
);

    localparam int CHUNKS = N / K;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;

    // Captured operands and running result
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  work_r;
    logic          carry_r;
    logic [CW-1:0] cnt_r;

    // Registered outputs
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  diff_r;
    logic          bout_r;
    logic          ovf_r;
    logic          zero_r;

    // Control strobes from the FSM
    logic          accept_s;
    logic          step_s;
    logic          load_s;
    logic          last_s;

    // Chunk datapath
    logic [31:0]   base_s;
    logic [K-1:0]  a_chunk_s;
    logic [K-1:0]  b_chunk_s;
    logic [K:0]    sum_s;
    logic          c_s;
    logic [N-1:0]  raw_s;
    logic [N-1:0]  diff_next_s;

    // One K-bit slice of a - b as a + ~b + carry; MSB of the result is carry out.
    function automatic logic [K:0] chunk_sub(
        input logic [K-1:0] x,
        input logic [K-1:0] y,
        input logic         cin
    );
        chunk_sub = {1'b0, x} + {1'b0, ~y} + {{K{1'b0}}, cin};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                    load_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                // start is deliberately not looked at here: no queuing.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Current chunk arithmetic and the result as it will look after this edge.
    always_comb begin
        last_s    = (cnt_r == LAST);
        base_s    = 32'(cnt_r) * 32'(K);
        a_chunk_s = a_r[base_s +: K];
        b_chunk_s = b_r[base_s +: K];
        sum_s     = chunk_sub(a_chunk_s, b_chunk_s, carry_r);
        c_s       = sum_s[K];
        raw_s     = work_r;
        raw_s[base_s +: K] = sum_s[K-1:0];
`ifdef SUB_SAT_EN
        // No carry out of the top chunk means a final borrow: clamp to zero.
        if (!c_s) begin
            diff_next_s = {N{1'b0}};
        end else begin
            diff_next_s = raw_s;
        end
`else
        diff_next_s = raw_s;
`endif
    end

    // Operand capture, chunk stepping and output loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            work_r  <= {N{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= {N{1'b0}};
            bout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r     <= bus.a;
                b_r     <= bus.b;
                carry_r <= ~bus.bin;
                cnt_r   <= {CW{1'b0}};
                work_r  <= {N{1'b0}};
            end else if (step_s) begin
                work_r  <= raw_s;
                carry_r <= c_s;
                // Counter returns to zero only on the way into DONE.
                cnt_r   <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            end else begin
                work_r  <= work_r;
            end

            busy_r <= (state_s == RUN);
            done_r <= load_s;

            if (load_s) begin
                diff_r <= diff_next_s;
                bout_r <= ~c_s;
                // Overflow uses the raw result even when saturation is built in.
                ovf_r  <= (a_r[N-1] != b_r[N-1]) && (raw_s[N-1] != a_r[N-1]);
                zero_r <= (diff_next_s == {N{1'b0}});
            end else begin
                diff_r <= diff_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;

endmodule

// File: tb/tb_sub_seq.sv
// tb_sub_seq: self-checking bench for sub_seq. Four instances share the operand
// inputs: (N=8,K=2), (N=8,K=1), (N=8,K=8) and (N=16,K=4); each has its own
// start. Expected results come from integer arithmetic on the operand values.
module tb_sub_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_v;
    logic [15:0] b_v;
    logic        bin_v;
    logic [3:0]  start_v;
    int          cur;
    int          total;
    int          bad;

    logic [15:0] o_diff;
    logic        o_busy, o_done, o_bout, o_ovf, o_zero;

    sub_seq_if #(.N(8))  bus0 ();
    sub_seq_if #(.N(8))  bus1 ();
    sub_seq_if #(.N(8))  bus2 ();
    sub_seq_if #(.N(16)) bus3 ();

    assign bus0.a = a_v[7:0];  assign bus0.b = b_v[7:0];  assign bus0.bin = bin_v;  assign bus0.start = start_v[0];
    assign bus1.a = a_v[7:0];  assign bus1.b = b_v[7:0];  assign bus1.bin = bin_v;  assign bus1.start = start_v[1];
    assign bus2.a = a_v[7:0];  assign bus2.b = b_v[7:0];  assign bus2.bin = bin_v;  assign bus2.start = start_v[2];
    assign bus3.a = a_v;       assign bus3.b = b_v;       assign bus3.bin = bin_v;  assign bus3.start = start_v[3];

    sub_seq #(.N(8),  .K(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sub_seq #(.N(8),  .K(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sub_seq #(.N(8),  .K(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    sub_seq #(.N(16), .K(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to common observation signals.
    always_comb begin
        o_diff = 16'h0000; o_busy = 1'b0; o_done = 1'b0;
        o_bout = 1'b0;     o_ovf  = 1'b0; o_zero = 1'b0;
        case (cur)
            0: begin o_diff = {8'h00, bus0.diff}; o_busy = bus0.busy; o_done = bus0.done; o_bout = bus0.bout; o_ovf = bus0.ovf; o_zero = bus0.zero; end
            1: begin o_diff = {8'h00, bus1.diff}; o_busy = bus1.busy; o_done = bus1.done; o_bout = bus1.bout; o_ovf = bus1.ovf; o_zero = bus1.zero; end
            2: begin o_diff = {8'h00, bus2.diff}; o_busy = bus2.busy; o_done = bus2.done; o_bout = bus2.bout; o_ovf = bus2.ovf; o_zero = bus2.zero; end
            3: begin o_diff = bus3.diff;          o_busy = bus3.busy; o_done = bus3.done; o_bout = bus3.bout; o_ovf = bus3.ovf; o_zero = bus3.zero; end
            default: begin o_diff = 16'h0000; end
        endcase
    end

    function automatic int width_of(input int c);
        return (c == 3) ? 16 : 8;
    endfunction

    function automatic int lat_of(input int c);
        case (c)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: plain integer subtraction, unsigned borrow and signed range test.
    function automatic void ref_sub(input int n, input logic [15:0] a, input logic [15:0] b,
                                    input logic bi, output logic [15:0] d, output logic bo,
                                    output logic ov, output logic z);
        int span, half, ua, ub, r, sa, sb, sr;
        span = 1 << n;
        half = span / 2;
        ua = int'(a) % span;
        ub = int'(b) % span;
        r  = ua - ub - int'(bi);
        bo = (r < 0);
        d  = 16'((r + span) % span);
        sa = (ua >= half) ? ua - span : ua;
        sb = (ub >= half) ? ub - span : ub;
        sr = sa - sb - int'(bi);
        ov = (sr < -half) || (sr > half - 1);
`ifdef SUB_SAT_EN
        if (bo) d = 16'h0000;
`endif
        z = (d == 16'h0000);
    endfunction

    // One operation on instance c; with mid set, start and operands churn during RUN/DONE.
    task automatic test_op(input int c, input logic [15:0] a, input logic [15:0] b,
                           input logic bi, input bit mid);
        logic [15:0] ed, cap_d;
        logic eb, eo, ez, cap_b, cap_o, cap_z;
        int L, busy_cnt, done_cnt, done_at;
        L = lat_of(c);
        ref_sub(width_of(c), a, b, bi, ed, eb, eo, ez);
        cap_d = 16'hxxxx; cap_b = 1'bx; cap_o = 1'bx; cap_z = 1'bx;
        cur = c;
        @(negedge clk);
        a_v = a; b_v = b; bin_v = bi; start_v[c] = 1'b1;
        @(posedge clk); #1;
        start_v[c] = 1'b0;
        a_v = 16'($urandom); b_v = 16'($urandom); bin_v = 1'($urandom);
        busy_cnt = o_busy ? 1 : 0;
        done_cnt = 0;
        done_at  = -1;
        for (int j = 1; j <= L + 2; j++) begin
            start_v[c] = (mid && j <= L + 1) ? 1'b1 : 1'b0;
            if (mid) begin a_v = 16'($urandom); b_v = 16'($urandom); bin_v = 1'($urandom); end
            @(posedge clk); #1;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = j; cap_d = o_diff; cap_b = o_bout; cap_o = o_ovf; cap_z = o_zero;
                end
            end
        end
        start_v[c] = 1'b0;
        total++; if (done_at !== L)    begin bad++; $display("FAIL latency cfg%0d: got %0d want %0d", c, done_at, L); end
        total++; if (busy_cnt !== L)   begin bad++; $display("FAIL busy_cycles cfg%0d: got %0d want %0d", c, busy_cnt, L); end
        total++; if (done_cnt !== 1)   begin bad++; $display("FAIL done_pulses cfg%0d: got %0d want 1", c, done_cnt); end
        total++; if (cap_d !== ed)     begin bad++; $display("FAIL diff cfg%0d a=%h b=%h bin=%b: got %h want %h", c, a, b, bi, cap_d, ed); end
        total++; if (cap_b !== eb)     begin bad++; $display("FAIL bout cfg%0d a=%h b=%h bin=%b: got %b want %b", c, a, b, bi, cap_b, eb); end
        total++; if (cap_o !== eo)     begin bad++; $display("FAIL ovf cfg%0d a=%h b=%h bin=%b: got %b want %b", c, a, b, bi, cap_o, eo); end
        total++; if (cap_z !== ez)     begin bad++; $display("FAIL zero cfg%0d a=%h b=%h bin=%b: got %b want %b", c, a, b, bi, cap_z, ez); end
        total++; if (o_diff !== ed)    begin bad++; $display("FAIL diff_hold cfg%0d: got %h want %h", c, o_diff, ed); end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            cur = c; #1;
            total++;
            if ({o_diff, o_busy, o_done, o_bout, o_ovf, o_zero} !== 21'h0) begin
                bad++; $display("FAIL reset_outputs cfg%0d: got %h want 0", c, {o_diff, o_busy, o_done, o_bout, o_ovf, o_zero});
            end
        end
    endtask

    task automatic test_vectors();
        for (int c = 0; c < 4; c++) begin
            test_op(c, 16'h0035, 16'h0012, 1'b0, 1'b0);
            test_op(c, 16'h0080, 16'h0001, 1'b0, 1'b0);
        end
        test_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0);
        test_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        test_op(3, 16'h1234, 16'h1235, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        test_op(0, 16'h005A, 16'h005A, 1'b0, 1'b1);
        test_op(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        test_op(2, 16'h0080, 16'h0001, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ed; logic eb, eo, ez;
        int first, second, L;
        L = 4; first = -1; second = -1;
        ref_sub(8, 16'h00C3, 16'h0047, 1'b1, ed, eb, eo, ez);
        cur = 0;
        @(negedge clk);
        a_v = 16'h00C3; b_v = 16'h0047; bin_v = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= 3 * (L + 2); j++) begin
            @(posedge clk); #1;
            if (o_done) begin
                if (first < 0) first = j;
                else if (second < 0) second = j;
            end
        end
        start_v[0] = 1'b0;
        for (int j = 0; j < L + 3; j++) @(posedge clk);
        #1;
        total++; if (second - first !== L + 2) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", second - first, L + 2); end
        total++; if (first !== L)              begin bad++; $display("FAIL b2b_first: got %0d want %0d", first, L); end
        total++; if (o_diff !== ed)            begin bad++; $display("FAIL b2b_diff: got %h want %h", o_diff, ed); end
        total++; if (o_busy !== 1'b0)          begin bad++; $display("FAIL b2b_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        test_op(0, 16'h0010, 16'h0020, 1'b0, 1'b0);
        cur = 0;
        @(negedge clk);
        a_v = 16'h0035; b_v = 16'h0012; bin_v = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_diff, o_busy, o_done, o_bout, o_ovf, o_zero} !== 21'h0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h want 0", {o_diff, o_busy, o_done, o_bout, o_ovf, o_zero});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL mid_reset_resumed: got %0d want 0", dones); end
        test_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
            test_op($urandom_range(0, 3), ra, rb, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        total = 0; bad = 0; cur = 0;
        rst_n = 1'b0; a_v = 16'h0000; b_v = 16'h0000; bin_v = 1'b0; start_v = 4'b0000;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
